// File: rtl/pulse_delay_meter.sv
// pulse_delay_meter
// Measures the delay from a trigger rising edge to the rising edge of a gate
// pulse, and the width of that pulse, both in clock cycles. Results are
// presented together with a one-cycle valid strobe.
//
// Optional feature macro: PULSE_DELAY_METER_SYNC_EN
//   When defined, trigger and pulse_in each pass through a 2-flop
//   synchronizer before use. When undefined, both inputs must already be
//   synchronous to clk.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   trigger    start reference, rising edge starts a measurement
//   pulse_in   gate pulse being measured
//   timeout    abort limit in cycles, 0 disables
//   delay_out  measured delay, held until next valid
//   width_out  measured width, held until next valid
//   valid      one-cycle strobe when results update
//   timed_out  1 when the current results come from an aborted measurement
//   busy       high while waiting for or measuring the pulse
module pulse_delay_meter #(
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          trigger,
   input  logic          pulse_in,
   input  logic [CW-1:0] timeout,
   output logic [CW-1:0] delay_out,
   output logic [CW-1:0] width_out,
   output logic          valid,
   output logic          timed_out,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   logic trig_s;
   logic pulse_s;

`ifdef PULSE_DELAY_METER_SYNC_EN
   logic [1:0] trig_sync_q, trig_sync_d;
   logic [1:0] pulse_sync_q, pulse_sync_d;

   // Both inputs see the same two-stage delay, so delay and width are
   // unaffected; only the pin-to-valid latency grows.
   always_comb begin
      trig_sync_d  = {trig_sync_q[0], trigger};
      pulse_sync_d = {pulse_sync_q[0], pulse_in};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         trig_sync_q  <= 2'b00;
         pulse_sync_q <= 2'b00;
      end else begin
         trig_sync_q  <= trig_sync_d;
         pulse_sync_q <= pulse_sync_d;
      end
   end

   assign trig_s  = trig_sync_q[1];
   assign pulse_s = pulse_sync_q[1];
`else
   assign trig_s  = trigger;
   assign pulse_s = pulse_in;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] dly_reg_q, dly_reg_d;
   logic [CW-1:0] wid_reg_q, wid_reg_d;
   logic          flag_q, flag_d;
   logic          trig_q, trig_d;
   logic [CW-1:0] delay_out_q, delay_out_d;
   logic [CW-1:0] width_out_q, width_out_d;
   logic          valid_q, valid_d;
   logic          timed_out_q, timed_out_d;
   logic          busy_q, busy_d;

   logic          trig_rise;
   logic          tmo_hit;
   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] cnt_one;

   assign trig_rise = trig_s && !trig_q;
   assign tmo_hit   = (timeout != '0) && (cnt_q >= timeout);
   // Counter holds at all-ones instead of wrapping so width never underflows.
   assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign cnt_one   = {{(CW-1){1'b0}}, 1'b1};

   // Next-state and datapath. Timeout is checked ahead of the pulse level so
   // that an expired limit always aborts, whatever the pulse is doing.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dly_reg_d   = dly_reg_q;
      wid_reg_d   = wid_reg_q;
      flag_d      = flag_q;
      trig_d      = trig_s;
      delay_out_d = delay_out_q;
      width_out_d = width_out_q;
      valid_d     = 1'b0;
      timed_out_d = timed_out_q;

      case (state_q)
         IDLE: begin
            if (trig_rise) begin
               cnt_d = cnt_one;
               if (pulse_s) begin
                  dly_reg_d = '0;
                  state_d   = HIGH;
               end else begin
                  state_d   = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_inc;
            if (tmo_hit) begin
               dly_reg_d = cnt_q;
               wid_reg_d = '0;
               flag_d    = 1'b1;
               state_d   = DONE;
            end else if (pulse_s) begin
               dly_reg_d = cnt_q;
               state_d   = HIGH;
            end
         end
         HIGH: begin
            cnt_d = cnt_inc;
            if (tmo_hit) begin
               wid_reg_d = cnt_q - dly_reg_q;
               flag_d    = 1'b1;
               state_d   = DONE;
            end else if (!pulse_s) begin
               wid_reg_d = cnt_q - dly_reg_q;
               state_d   = DONE;
            end
         end
         DONE: begin
            delay_out_d = dly_reg_q;
            width_out_d = wid_reg_q;
            valid_d     = 1'b1;
            timed_out_d = flag_q;
            flag_d      = 1'b0;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered busy follows the state being entered.
      busy_d = (state_d == WAIT) || (state_d == HIGH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dly_reg_q   <= '0;
         wid_reg_q   <= '0;
         flag_q      <= 1'b0;
         trig_q      <= 1'b0;
         delay_out_q <= '0;
         width_out_q <= '0;
         valid_q     <= 1'b0;
         timed_out_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dly_reg_q   <= dly_reg_d;
         wid_reg_q   <= wid_reg_d;
         flag_q      <= flag_d;
         trig_q      <= trig_d;
         delay_out_q <= delay_out_d;
         width_out_q <= width_out_d;
         valid_q     <= valid_d;
         timed_out_q <= timed_out_d;
         busy_q      <= busy_d;
      end
   end

   assign delay_out = delay_out_q;
   assign width_out = width_out_q;
   assign valid     = valid_q;
   assign timed_out = timed_out_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_pulse_delay_meter.sv
// Testbench for pulse_delay_meter.
// Each vector describes a trigger/pulse pattern relative to the clock edge on
// which the trigger is first sampled, plus the expected results and the
// iteration at which valid should be observed (unsynchronized build; the
// synchronized build adds two cycles).
module tb_pulse_delay_meter;

`ifdef PULSE_DELAY_METER_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        trigger;
   logic        pulse_in;
   logic [31:0] timeout;
   logic [31:0] delay_out;
   logic [31:0] width_out;
   logic        valid;
   logic        timed_out;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      int          trigHold;
      int          retrigAt;
      int          dly;
      int          wid;
      logic [31:0] tmo;
      logic [31:0] expDelay;
      logic [31:0] expWidth;
      logic        expTimedOut;
      int          expValidIter;
   } vec_t;

   vec_t vecs[9];
   vec_t afterReset;

   pulse_delay_meter #(.CW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .trigger   (trigger),
      .pulse_in  (pulse_in),
      .timeout   (timeout),
      .delay_out (delay_out),
      .width_out (width_out),
      .valid     (valid),
      .timed_out (timed_out),
      .busy      (busy)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Compare one observed value with its expected value and log mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Run one measurement. Iteration i samples outputs at the falling edge
   // (reflecting rising edge i-1) and then drives inputs for rising edge i.
   task automatic applyStimulus(input vec_t v);
      int          validCount = 0;
      int          validIter  = -1;
      logic [31:0] gotDelay   = '0;
      logic [31:0] gotWidth   = '0;
      logic        gotTo      = 1'b0;
      logic        gotBusyAtValid = 1'b1;
      logic        busyEarly  = 1'b0;
      int          last;
      last = v.expValidIter + LAT;
      if (v.trigHold > last) last = v.trigHold;
      if (v.dly + v.wid > last) last = v.dly + v.wid;
      last = last + 6;
      timeout = v.tmo;
      for (int i = 0; i <= last; i++) begin
         @(negedge clk);
         if (valid) begin
            validCount++;
            if (validIter < 0) begin
               validIter      = i;
               gotDelay       = delay_out;
               gotWidth       = width_out;
               gotTo          = timed_out;
               gotBusyAtValid = busy;
            end
         end
         if (i == LAT + 1) busyEarly = busy;
         trigger  = (i < v.trigHold) || (i == v.retrigAt);
         pulse_in = (i >= v.dly) && (i < v.dly + v.wid);
      end
      checkOutput({v.name, " valid_count"}, validCount, 1);
      checkOutput({v.name, " valid_cycle"}, validIter, v.expValidIter + LAT);
      checkOutput({v.name, " delay_out"}, gotDelay, v.expDelay);
      checkOutput({v.name, " width_out"}, gotWidth, v.expWidth);
      checkOutput({v.name, " timed_out"}, {31'd0, gotTo}, {31'd0, v.expTimedOut});
      checkOutput({v.name, " busy_early"}, {31'd0, busyEarly}, 32'd1);
      checkOutput({v.name, " busy_at_valid"}, {31'd0, gotBusyAtValid}, 32'd0);
      checkOutput({v.name, " delay_held"}, delay_out, v.expDelay);
      trigger  = 1'b0;
      pulse_in = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      // name, trigHold, retrigAt, dly, wid, timeout, expDelay, expWidth, expTimedOut, expValidIter
      vecs[0] = '{"basic",           1, -1,  5,  7, 32'd0,   32'd5,  32'd7, 1'b0, 14};
      vecs[1] = '{"zero_delay",      1, -1,  0,  3, 32'd0,   32'd0,  32'd3, 1'b0,  5};
      vecs[2] = '{"timeout_wait",    1, -1,  0,  0, 32'd20,  32'd20, 32'd0, 1'b1, 22};
      vecs[3] = '{"retrigger",       1,  3, 10,  4, 32'd0,   32'd10, 32'd4, 1'b0, 16};
      vecs[4] = '{"timeout_high",    1, -1,  3, 20, 32'd8,   32'd3,  32'd5, 1'b1, 10};
      vecs[5] = '{"held_trigger",   30, -1,  2,  2, 32'd0,   32'd2,  32'd2, 1'b0,  6};
      vecs[6] = '{"min_pulse",       1, -1,  1,  1, 32'd0,   32'd1,  32'd1, 1'b0,  4};
      vecs[7] = '{"timeout_not_hit", 1, -1,  4,  6, 32'd100, 32'd4,  32'd6, 1'b0, 12};
      vecs[8] = '{"timeout_high_b",  1, -1,  5,  4, 32'd6,   32'd5,  32'd1, 1'b1,  8};
      afterReset = '{"after_reset",  1, -1,  2,  2, 32'd0,   32'd2,  32'd2, 1'b0,  6};

      rst      = 1'b1;
      trigger  = 1'b0;
      pulse_in = 1'b0;
      timeout  = 32'd0;
      repeat (3) @(negedge clk);
      checkOutput("reset delay_out", delay_out, 32'd0);
      checkOutput("reset width_out", width_out, 32'd0);
      checkOutput("reset valid", {31'd0, valid}, 32'd0);
      checkOutput("reset timed_out", {31'd0, timed_out}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int k = 0; k < 9; k++) applyStimulus(vecs[k]);

      // Reset asserted while the pulse is being measured: outputs clear and
      // no result is ever reported for the aborted measurement.
      begin
         int validSeen = 0;
         timeout = 32'd0;
         for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (valid) validSeen++;
            if (i == 6) begin
               checkOutput("mid_reset delay_out", delay_out, 32'd0);
               checkOutput("mid_reset width_out", width_out, 32'd0);
               checkOutput("mid_reset timed_out", {31'd0, timed_out}, 32'd0);
               checkOutput("mid_reset busy", {31'd0, busy}, 32'd0);
            end
            trigger  = (i == 0);
            pulse_in = (i >= 2) && (i < 12);
            rst      = (i == 5);
         end
         checkOutput("mid_reset valid_count", validSeen, 0);
         trigger  = 1'b0;
         pulse_in = 1'b0;
         rst      = 1'b0;
         repeat (3) @(negedge clk);
      end

      applyStimulus(afterReset);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
